// File: rtl/fp_convert_stream_if.sv
// fp_convert_stream_if
//   Stream bundle for fp_convert_stream: one input beat channel and one output
//   beat channel, each carrying LANES packed fixed-point words.
//
//   Handshake semantics (both channels): a beat transfers on a rising clock
//   edge where valid && ready. A producer holding valid keeps its payload
//   stable until the transfer; ready may depend combinationally on the
//   consumer's own downstream ready, but valid never depends on ready.
//
//   Signals
//     in_valid  : input beat valid (producer -> converter)
//     in_ready  : converter can accept a beat
//     in_data   : LANES*IW bits, lane k at [k*IW +: IW]
//     in_mode   : rounding mode, applies to every lane of the beat
//     out_valid : output beat valid (converter -> consumer)
//     out_ready : consumer accepts the output beat
//     out_data  : LANES*OW bits, lane k at [k*OW +: OW]
//     out_sat   : per-lane saturation flags of the current output beat
//
//   Modports: master = the side that feeds input beats and consumes output
//   beats (testbench / surrounding pipeline); slave = the converter.
interface fp_convert_stream_if #(
  parameter int LANES = 4,
  parameter int IW    = 64,
  parameter int OW    = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IW-1:0]   in_data;
  logic [1:0]            in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OW-1:0]   out_data;
  logic [LANES-1:0]      out_sat;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat
  );
endinterface

// File: rtl/fp_convert_stream.sv
// fp_convert_stream
//   Streaming multi-lane fixed-point format converter. Each lane converts a
//   Q(IIBITS).(IFBITS) word to Q(OIBITS).(OFBITS) with one of four rounding
//   modes, clamps out-of-range results to the output range and flags them.
//   A running counter records how many transferred output beats contained a
//   saturated lane.
//
//   Rounding modes (in_mode):
//     0 floor (toward -inf)
//     1 round half up (add half an output LSB, then floor)
//     2 round half to even
//     3 toward zero (identical to floor for unsigned data)
//
//   Ports
//     clk       : clock, all state on the rising edge
//     rst_n     : synchronous active-low reset
//     bus       : fp_convert_stream_if.slave (input/output beat channels)
//     sat_count : beats transferred with any lane saturated, sticks at all-ones
//     sat_clear : synchronous clear of sat_count (an increment in the same
//                 cycle still counts, giving 1)
//
//   Pipeline
//     S1 captures the floored (shifted) value and a 1-bit round increment per
//     lane. The rounding mode is folded into that increment at capture time,
//     so a beat keeps the mode it arrived with even if in_mode changes later.
//     S2 adds the increment, range-checks the rounded value and registers the
//     clamped result and flags. Latency 2, throughput 1 beat/cycle, no skid
//     buffer: in_ready is combinational from out_ready.
module fp_convert_stream #(
  parameter int IIBITS        = 24,
  parameter int IFBITS        = 40,
  parameter int OIBITS        = 12,
  parameter int OFBITS        = 20,
  parameter int SIGNED_VALUES = 1,
  parameter int LANES         = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_convert_stream_if.slave   bus,
  output logic [CNT_BITS-1:0]  sat_count,
  input  logic                 sat_clear
);

  localparam int IW  = IIBITS + IFBITS;
  localparam int OW  = OIBITS + OFBITS;
  // Positive SH: fraction bits to drop. Negative: widen by left shift.
  localparam int SH  = IFBITS - OFBITS;
  localparam int LSH = (SH < 0) ? -SH : 0;
  // Width of the rounded value before the range check; one spare bit keeps a
  // rounding carry out of the top.
  localparam int WW  = IIBITS + OFBITS + 1;
  // Internal working width: wide enough for the input, the rounded value and
  // the output bounds, plus headroom so signed compares never wrap.
  localparam int CW_A = (IW > WW) ? IW : WW;
  localparam int CW   = ((CW_A > OW) ? CW_A : OW) + 2;

  localparam logic signed [CW-1:0] MAX_V = (SIGNED_VALUES != 0)
    ? ((CW'(1) << (OW - 1)) - CW'(1))
    : ((CW'(1) << OW) - CW'(1));
  localparam logic signed [CW-1:0] MIN_V = (SIGNED_VALUES != 0)
    ? -(CW'(1) << (OW - 1))
    : '0;

  // ---------------------------------------------------------------------
  // Advance control
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic adv1;
  logic adv2;

  assign adv2         = !bus.out_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  // ---------------------------------------------------------------------
  // Stage 1 combinational: floor-shift and round increment per lane
  // ---------------------------------------------------------------------
  logic [LANES-1:0][CW-1:0] s1_q_d;
  logic [LANES-1:0]         s1_inc_d;

  for (genvar k = 0; k < LANES; k++) begin : g_s1_lane
    logic [IW-1:0] x;
    logic          sx;   // sign-extension bit; always 0 for unsigned data

    assign x  = bus.in_data[k*IW +: IW];
    assign sx = (SIGNED_VALUES != 0) && x[IW-1];

    if (SH > 0) begin : g_narrow
      logic [CW-1:0] q;
      logic          guard;
      logic          sticky;
      logic          inc;

      // Arithmetic right shift by SH == floor(x / 2^SH) for both signednesses.
      assign q     = {{(CW - IW + SH){sx}}, x[IW-1:SH]};
      assign guard = x[SH-1];

      if (SH > 1) begin : g_sticky
        assign sticky = |x[SH-2:0];
      end else begin : g_no_sticky
        assign sticky = 1'b0;
      end

      // Floor is the base result; every mode is "floor plus 0 or 1 LSB".
      always_comb begin
        inc = 1'b0;
        case (bus.in_mode)
          2'd0:    inc = 1'b0;
          2'd1:    inc = guard;
          2'd2:    inc = guard && (sticky || q[0]);
          default: inc = sx && (guard || sticky);  // negative, inexact: step up toward zero
        endcase
      end

      assign s1_q_d[k]   = q;
      assign s1_inc_d[k] = inc;
    end else begin : g_widen
      logic [CW-1:0] xe;

      // Widening is an exact left shift; rounding has nothing to do.
      assign xe          = {{(CW - IW){sx}}, x};
      assign s1_q_d[k]   = xe << LSH;
      assign s1_inc_d[k] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic [LANES-1:0][CW-1:0] s1_q;
  logic [LANES-1:0]         s1_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_inc   <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      // Bubbles leave the data registers untouched.
      if (bus.in_valid) begin
        s1_q   <= s1_q_d;
        s1_inc <= s1_inc_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 combinational: apply increment, range check, clamp
  // ---------------------------------------------------------------------
  logic [LANES-1:0][OW-1:0] s2_data_d;
  logic [LANES-1:0]         s2_sat_d;

  for (genvar k = 0; k < LANES; k++) begin : g_s2_lane
    logic signed [CW-1:0] r;
    logic                 over;
    logic                 under;

    // The check runs on the rounded value, so a carry past the maximum
    // saturates instead of wrapping.
    assign r     = $signed(s1_q[k] + CW'(s1_inc[k]));
    assign over  = (r > MAX_V);
    assign under = (r < MIN_V);

    assign s2_sat_d[k]  = over || under;
    assign s2_data_d[k] = over  ? MAX_V[OW-1:0] :
                          under ? MIN_V[OW-1:0] :
                                  r[OW-1:0];
  end

  // ---------------------------------------------------------------------
  // Stage 2 registers (drive the output channel directly)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= '0;
    end else if (adv2) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= s2_data_d;
        bus.out_sat  <= s2_sat_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Saturation event counter
  // ---------------------------------------------------------------------
  logic sat_hit;

  assign sat_hit = bus.out_valid && bus.out_ready && (|bus.out_sat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      // Clear replaces the base value; a simultaneous event still counts.
      sat_count <= sat_hit ? CNT_BITS'(1) : '0;
    end else if (sat_hit && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_BITS'(1);
    end
  end

endmodule
